// File: rtl/fifo_arb_tx_n_if.sv
// fifo_arb_tx_n_if
//   Bundles the per-channel write ports and the downstream FIFO write port
//   of the packet arbiter.
//   master : traffic source / downstream sink side (drives channel writes and fifo_wrfull)
//   slave  : the arbiter
//   c_wren/c_wrdata/c_wrfull/c_ovf : per-channel write side, channel i data at [i*DWIDTH +: DWIDTH]
//   fifo_wren/fifo_wrdata/fifo_wrfull : merged downstream write port
//   busy : a grant is held
interface fifo_arb_tx_n_if #(
    parameter int DWIDTH = 8,
    parameter int NCH    = 4
);
    logic [NCH-1:0]        c_wren;
    logic [NCH*DWIDTH-1:0] c_wrdata;
    logic [NCH-1:0]        c_wrfull;
    logic [NCH-1:0]        c_ovf;
    logic                  fifo_wren;
    logic                  fifo_wrfull;
    logic [DWIDTH-1:0]     fifo_wrdata;
    logic                  busy;

    modport master (
        output c_wren, c_wrdata, fifo_wrfull,
        input  c_wrfull, c_ovf, fifo_wren, fifo_wrdata, busy
    );

    modport slave (
        input  c_wren, c_wrdata, fifo_wrfull,
        output c_wrfull, c_ovf, fifo_wren, fifo_wrdata, busy
    );
endinterface

// File: rtl/fifo_arb_tx_n.sv
// fifo_arb_tx_n
//   N-channel packet-aware TX arbiter. Each channel owns a 2^IAW-entry buffer;
//   complete packets (header + length-field payload bytes) are merged round-robin
//   into one downstream FIFO write port without interleaving. The granted channel
//   id is written into the SEL field of each header.
//   Ports: CLK, RESETn (async active-low), bus (fifo_arb_tx_n_if.slave).
//   The SEL field [SELSHIFT+CHW-1:SELSHIFT] and length field
//   [CNTSHIFT+CNTW-1:CNTSHIFT] must both lie inside DWIDTH and not overlap.

// Per-channel input buffer.
//   wren/wrdata : write port; full/ovf : registered full and sticky overflow
//   pop         : consume head (ignored when empty)
//   head/head_vld : current head entry
//   ready       : buffer has been non-empty for a full cycle (arbitration view)
module fifo_arb_tx_n_chbuf #(
    parameter int DWIDTH = 8,
    parameter int IAW    = 3
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic              wren,
    input  logic [DWIDTH-1:0] wrdata,
    input  logic              pop,
    output logic              full,
    output logic              ovf,
    output logic [DWIDTH-1:0] head,
    output logic              head_vld,
    output logic              ready
);
    localparam int DEPTH = 1 << IAW;

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [IAW-1:0]    wr_ptr, rd_ptr;
    logic [IAW:0]      count, count_nxt;
    logic              push, pop_ok;

    // full is the registered flag, so a push in the same cycle as a pop on a
    // full buffer is still rejected
    assign push   = wren & ~full;
    assign pop_ok = pop & (count != '0);

    always_comb begin
        count_nxt = count + {{IAW{1'b0}}, push} - {{IAW{1'b0}}, pop_ok};
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            ovf    <= 1'b0;
            ready  <= 1'b0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == (IAW+1)'(DEPTH));
            ovf   <= ovf | (wren & full);
            // Non-empty both before and after this edge: gives the arbiter a
            // one-cycle look at a fresh write and never shows a buffer that
            // has just been drained.
            ready <= (count != '0) && (count_nxt != '0);
        end
    end

    // Storage needs no reset; count gates validity
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= wrdata;
    end

    assign head     = mem[rd_ptr];
    assign head_vld = (count != '0);
endmodule

module fifo_arb_tx_n #(
    parameter int DWIDTH   = 8,
    parameter int NCH      = 4,
    parameter int IAW      = 3,
    parameter int SELSHIFT = 6,
    parameter int CNTSHIFT = 3,
    parameter int CNTW     = 3
) (
    input  logic          CLK,
    input  logic          RESETn,
    fifo_arb_tx_n_if.slave bus
);
    localparam int CHW = $clog2(NCH);

    typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

    state_t                        state;
    logic [CHW-1:0]                grant;      // also serves as rr_last
    logic [CNTW-1:0]               cnt;
    logic                          busy_q;

    logic [NCH-1:0]                pop, head_vld, ready, full_v, ovf_v;
    logic [NCH-1:0][DWIDTH-1:0]    head;
    logic [CHW-1:0]                pick;
    logic                          pick_vld;
    logic [DWIDTH-1:0]             sel_head, wdata;
    logic                          sel_vld, fire;
    logic [CNTW-1:0]               hdr_len;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        fifo_arb_tx_n_chbuf #(
            .DWIDTH (DWIDTH),
            .IAW    (IAW)
        ) u_buf (
            .CLK      (CLK),
            .RESETn   (RESETn),
            .wren     (bus.c_wren[i]),
            .wrdata   (bus.c_wrdata[i*DWIDTH +: DWIDTH]),
            .pop      (pop[i]),
            .full     (full_v[i]),
            .ovf      (ovf_v[i]),
            .head     (head[i]),
            .head_vld (head_vld[i]),
            .ready    (ready[i])
        );
        assign pop[i] = fire && (grant == CHW'(i));
    end

    assign bus.c_wrfull = full_v;
    assign bus.c_ovf    = ovf_v;
    assign bus.busy     = busy_q;

    // Round-robin pick: scan from farthest to nearest so the first ready
    // channel after rr_last wins.
    always_comb begin
        int idx;
        idx      = 0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = NCH; k >= 1; k--) begin
            idx = (int'(grant) + k) % NCH;
            if (ready[idx]) begin
                pick     = CHW'(idx);
                pick_vld = 1'b1;
            end
        end
    end

    assign sel_head = head[grant];
    assign sel_vld  = head_vld[grant];
    assign hdr_len  = sel_head[CNTSHIFT +: CNTW];

    // RESETn term keeps the strobe low for the whole reset assertion
    assign fire = RESETn && (state != IDLE) && sel_vld && !bus.fifo_wrfull;

    always_comb begin
        wdata = sel_head;
        if (state == HDR) wdata[SELSHIFT +: CHW] = grant;
    end

    assign bus.fifo_wren   = fire;
    assign bus.fifo_wrdata = wdata;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state  <= IDLE;
            grant  <= CHW'(NCH-1);
            cnt    <= '0;
            busy_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        grant  <= pick;
                        state  <= HDR;
                        busy_q <= 1'b1;
                    end
                end
                HDR: begin
                    if (fire) begin
                        cnt <= hdr_len;
                        if (hdr_len == '0) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            state <= PAY;
                        end
                    end
                end
                PAY: begin
                    if (fire) begin
                        cnt <= cnt - 1'b1;
                        if (cnt == CNTW'(1)) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end
endmodule
